// File: rtl/uart_pkg.sv
// Shared UART constants and types for the receiver, transmitter and receive buffer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_pkg;

    localparam int UART_DATA_W         = 8;
    localparam int UART_CLKS_PER_BIT   = 10416;
    localparam int UART_RX_FIFO_DEPTH  = 16;
    localparam int UART_RX_FIFO_THRESH = 8;

    typedef logic [UART_DATA_W-1:0] uart_byte_t;

endpackage

// File: rtl/uart_fifo_ram.sv
// Byte storage for the receive FIFO: one synchronous write port, one registered read port.
// Latency: read data appears one cycle after rd_vld; a read and a write to the same address return the old byte.
// Backpressure: none; the caller only issues accepted operations.
module uart_fifo_ram
    import uart_pkg::*;
#(
    parameter int DEPTH  = UART_RX_FIFO_DEPTH,
    parameter int ADDR_W = 4
) (
    input  logic                   UART_CLK,
    input  logic                   reset,
    input  logic                   wr_vld,
    input  logic [ADDR_W-1:0]      wr_addr,
    input  logic [UART_DATA_W-1:0] wr_dat,
    input  logic                   rd_vld,
    input  logic [ADDR_W-1:0]      rd_addr,
    output logic [UART_DATA_W-1:0] rd_dat
);

    uart_byte_t mem_q [DEPTH];
    uart_byte_t rd_dat_q;
    uart_byte_t rd_dat_d;

    // The array itself is never reset; its contents are meaningless until written.
    always_ff @(posedge UART_CLK) begin
        if (wr_vld) begin
            mem_q[wr_addr] <= wr_dat;
        end
    end

    // The output register holds its value between reads.
    always_comb begin
        rd_dat_d = rd_dat_q;
        if (rd_vld) begin
            rd_dat_d = mem_q[rd_addr];
        end
    end

    always_ff @(posedge UART_CLK or posedge reset) begin
        if (reset) begin
            rd_dat_q <= '0;
        end else begin
            rd_dat_q <= rd_dat_d;
        end
    end

    assign rd_dat = rd_dat_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive byte FIFO between the UART receiver and the register block, with status, sticky overrun and irq.
// Latency: read data and rd_valid one cycle after an accepted rd_en; flags valid one cycle after the event.
// Backpressure: none upstream; bytes arriving while full are dropped and flagged as overrun.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH  = UART_RX_FIFO_DEPTH,
    parameter int ADDR_W = 4,
    parameter int THRESH = UART_RX_FIFO_THRESH
) (
    input  logic                   UART_CLK,
    input  logic                   reset,
    input  logic                   rx_ready,
    input  logic [UART_DATA_W-1:0] rx_data,
    input  logic                   rd_en,
    input  logic                   flush,
    input  logic                   clr_ovr,
    output logic [UART_DATA_W-1:0] rd_data,
    output logic                   rd_valid,
    output logic                   empty,
    output logic                   full,
    output logic [ADDR_W:0]        count,
    output logic                   overrun,
    output logic                   irq
);

    localparam logic [ADDR_W:0]   DEPTH_C  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   THRESH_C = (ADDR_W+1)'(THRESH);
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              rd_valid_q, rd_valid_d;
    logic              overrun_q, overrun_d;

    logic is_empty;
    logic is_full;
    logic rd_acc;
    logic wr_acc;
    logic ovr_evt;

    always_comb begin
        is_empty = (count_q == '0);
        is_full  = (count_q == DEPTH_C);

        // A read on a full FIFO frees the slot the concurrent write lands in, so
        // the write is taken and no overrun is raised. An empty FIFO never
        // forwards the incoming byte to the read port in the same cycle.
        rd_acc  = rd_en && !flush && !is_empty;
        wr_acc  = rx_ready && !flush && (!is_full || rd_acc);
        ovr_evt = rx_ready && !flush && is_full && !rd_acc;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_acc) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (rd_acc) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
            count_d = count_q + (ADDR_W+1)'(wr_acc) - (ADDR_W+1)'(rd_acc);
        end

        rd_valid_d = rd_acc;

        // A drop in the same cycle as clr_ovr keeps the flag set.
        overrun_d = overrun_q;
        if (ovr_evt) begin
            overrun_d = 1'b1;
        end else if (clr_ovr) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge UART_CLK or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rd_valid_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rd_valid_q <= rd_valid_d;
            overrun_q  <= overrun_d;
        end
    end

    uart_fifo_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .UART_CLK (UART_CLK),
        .reset    (reset),
        .wr_vld   (wr_acc),
        .wr_addr  (wr_ptr_q),
        .wr_dat   (rx_data),
        .rd_vld   (rd_acc),
        .rd_addr  (rd_ptr_q),
        .rd_dat   (rd_data)
    );

    assign rd_valid = rd_valid_q;
    assign count    = count_q;
    assign empty    = (count_q == '0);
    assign full     = (count_q == DEPTH_C);
    assign overrun  = overrun_q;
    assign irq      = (count_q >= THRESH_C) || overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: a queue-based model predicts flags and read bytes,
// a negedge monitor pops expected bytes whenever rd_valid is seen.
module tb_uart_rx_fifo;

    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;
    localparam int THRESH = 8;

    logic            UART_CLK;
    logic            reset;
    logic            rx_ready;
    logic [7:0]      rx_data;
    logic            rd_en;
    logic            flush;
    logic            clr_ovr;
    logic [7:0]      rd_data;
    logic            rd_valid;
    logic            empty;
    logic            full;
    logic [ADDR_W:0] count;
    logic            overrun;
    logic            irq;

    uart_rx_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .THRESH (THRESH)
    ) dut (
        .UART_CLK (UART_CLK),
        .reset    (reset),
        .rx_ready (rx_ready),
        .rx_data  (rx_data),
        .rd_en    (rd_en),
        .flush    (flush),
        .clr_ovr  (clr_ovr),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .empty    (empty),
        .full     (full),
        .count    (count),
        .overrun  (overrun),
        .irq      (irq)
    );

    initial begin
        UART_CLK = 1'b0;
        forever #5 UART_CLK = ~UART_CLK;
    end

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] m_q[$];
    logic [7:0] exp_q[$];
    logic       m_ovr  = 1'b0;
    logic [7:0] m_last = 8'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: the FIFO is a byte queue of capacity DEPTH.
    task automatic model_apply(input logic rx, input logic [7:0] d, input logic re,
                               input logic fl, input logic co);
        bit rd_ok, wr_ok, drop;
        logic [7:0] b;
        drop = 1'b0;
        if (fl) begin
            m_q.delete();
        end else begin
            rd_ok = re && (m_q.size() > 0);
            wr_ok = rx && ((m_q.size() < DEPTH) || rd_ok);
            drop  = rx && !wr_ok;
            if (rd_ok) begin
                b = m_q.pop_front();
                exp_q.push_back(b);
                m_last = b;
            end
            if (wr_ok) m_q.push_back(d);
        end
        if (drop) m_ovr = 1'b1;
        else if (co) m_ovr = 1'b0;
    endtask

    task automatic check_flags();
        chk("count",   count,    m_q.size());
        chk("empty",   empty,    m_q.size() == 0);
        chk("full",    full,     m_q.size() == DEPTH);
        chk("overrun", overrun,  m_ovr);
        chk("irq",     irq,      (m_q.size() >= THRESH) || m_ovr);
        chk("rd_data_hold", rd_data, m_last);
    endtask

    task automatic step(input logic rx, input logic [7:0] d, input logic re,
                        input logic fl, input logic co);
        @(negedge UART_CLK);
        rx_ready = rx;
        rx_data  = d;
        rd_en    = re;
        flush    = fl;
        clr_ovr  = co;
        model_apply(rx, d, re, fl, co);
        @(posedge UART_CLK);
        #1;
        rx_ready = 1'b0;
        rd_en    = 1'b0;
        flush    = 1'b0;
        clr_ovr  = 1'b0;
        check_flags();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rd_valid"}, rd_valid, 0);
        chk({tag, "_rd_data"},  rd_data,  0);
        chk({tag, "_count"},    count,    0);
        chk({tag, "_empty"},    empty,    1);
        chk({tag, "_full"},     full,     0);
        chk({tag, "_overrun"},  overrun,  0);
        chk({tag, "_irq"},      irq,      0);
    endtask

    // Monitor: every rd_valid pulse must match the oldest predicted read.
    initial begin
        forever begin
            @(negedge UART_CLK);
            if (!reset && rd_valid) begin
                if (exp_q.size() == 0) begin
                    chk("rd_valid_unexpected", rd_valid, 0);
                end else begin
                    chk("rd_data", rd_data, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        logic [7:0] pat;
        reset    = 1'b1;
        rx_ready = 1'b0;
        rx_data  = 8'h00;
        rd_en    = 1'b0;
        flush    = 1'b0;
        clr_ovr  = 1'b0;
        #12;
        check_reset_outputs("reset");
        @(negedge UART_CLK);
        reset = 1'b0;

        // Basic ordering.
        step(1, 8'h41, 0, 0, 0);
        step(1, 8'h42, 0, 0, 0);
        step(1, 8'h43, 0, 0, 0);
        repeat (3) step(0, 8'h00, 1, 0, 0);

        // Fill, overrun, clear, then full with simultaneous read and write.
        for (int i = 0; i < DEPTH; i++) step(1, 8'(i), 0, 0, 0);
        step(1, 8'hFF, 0, 0, 0);
        step(0, 8'h00, 0, 0, 1);
        step(1, 8'hA5, 1, 0, 0);
        repeat (DEPTH) step(0, 8'h00, 1, 0, 0);

        // Empty-FIFO corner cases.
        step(0, 8'h00, 1, 0, 0);
        step(1, 8'h5A, 1, 0, 0);
        step(0, 8'h00, 1, 0, 0);

        // Pointer wrap with interleaved traffic.
        pat = 8'h80;
        for (int i = 0; i < 40; i++) begin
            step(1, pat, 0, 0, 0);
            step(0, 8'h00, 1, 0, 0);
            pat = pat + 8'd1;
        end

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 99) < 60, 8'($urandom), $urandom_range(0, 99) < 45,
                 $urandom_range(0, 99) < 2, $urandom_range(0, 99) < 5);
        end

        // Flush with overrun set, 5 bytes queued and a concurrent write.
        step(0, 8'h00, 0, 1, 1);
        for (int i = 0; i <= DEPTH; i++) step(1, 8'(8'h10 + i), 0, 0, 0);
        repeat (DEPTH - 5) step(0, 8'h00, 1, 0, 0);
        step(1, 8'hEE, 0, 1, 0);
        step(1, 8'h77, 0, 0, 0);
        step(1, 8'h78, 0, 0, 0);

        // Asynchronous reset while a read result is being presented.
        step(0, 8'h00, 1, 0, 0);
        chk("rd_valid_before_reset", rd_valid, 1);
        #1 reset = 1'b1;
        #1;
        check_reset_outputs("async_reset");
        exp_q.delete();
        m_q.delete();
        m_ovr  = 1'b0;
        m_last = 8'h00;
        repeat (2) @(posedge UART_CLK);
        @(negedge UART_CLK);
        reset = 1'b0;
        step(1, 8'h3C, 0, 0, 0);
        step(0, 8'h00, 1, 0, 0);

        repeat (3) @(posedge UART_CLK);
        chk("pending_reads", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Receive-side buffer directly downstream of the UART receiver.
- Captures each received byte on the receiver's one-cycle `rx_ready` strobe and queues it in a DEPTH-entry FIFO.
- Presents the bytes to the processor's memory-mapped UART register block through a registered read port.
- Provides status flags, a sticky overrun flag and a threshold interrupt, all in the UART_CLK domain.

Parameters:
- DEPTH, 16, number of byte entries; power of two, ≥2.
- ADDR_W, 4, log2(DEPTH); pointer width.
- THRESH, 8, fill level (1..DEPTH) at or above which irq asserts.

Ports:
- UART_CLK  input  1  block clock.
- reset  input  1  asynchronous, active-high reset.
- rx_ready  input  1  one-cycle strobe from the receiver: rx_data is valid.
- rx_data  input  8  received byte.
- rd_en  input  1  processor read request; pop one byte.
- flush  input  1  discard all queued bytes.
- clr_ovr  input  1  clear the sticky overrun flag.
- rd_data  output  8  byte returned by the last accepted read.
- rd_valid  output  1  one-cycle pulse: rd_data updated this cycle.
- empty  output  1  count == 0.
- full  output  1  count == DEPTH.
- count  output  ADDR_W+1  current fill level, 0..DEPTH.
- overrun  output  1  sticky: a byte was dropped because the FIFO was full.
- irq  output  1  (count ≥ THRESH) OR overrun.

Behaviour:
- Reset (asynchronous, active-high; clock UART_CLK):
  - wr_ptr, rd_ptr, count, rd_data, rd_valid and overrun all go to 0.
  - empty=1, full=0, irq=0.
  - Memory contents are don't-care.
- Write:
  - rx_ready=1 and not full: mem[wr_ptr]<=rx_data, wr_ptr increments mod DEPTH, count+1.
  - rx_ready=1 and full: byte dropped, pointers unchanged, overrun<=1.
- Read:
  - rd_en=1 and not empty: rd_data<=mem[rd_ptr], rd_ptr increments mod DEPTH, count-1.
  - rd_valid=1 on the following cycle (registered, 1-cycle latency).
  - rd_en=1 while empty: ignored; rd_valid stays 0, rd_data holds its last value, no error flag.
  - rd_valid is 0 in every cycle without an accepted read.
- Simultaneous rx_ready and rd_en:
  - Not empty and not full: both occur, count unchanged.
  - Full: the read frees a slot, so the write is accepted and no overrun is raised.
  - Empty: the write is accepted and the read is ignored (no fall-through); count=1 next cycle.
- Flush:
  - Has priority over rd_en and rx_ready in the same cycle.
  - wr_ptr=rd_ptr=count=0; the incoming byte is discarded; no rd_valid pulse.
  - Does not change overrun.
- clr_ovr: overrun<=0, except that an overrun event in the same cycle wins and overrun stays 1.
- Flags: empty, full, count and irq are derived combinationally from the registered count and overrun, so they are valid the cycle after the causing event.
- Pointer wrap: pointers are ADDR_W bits and wrap naturally from DEPTH-1 to 0. Full/empty are taken from count, not from pointer comparison.
- count arithmetic: ADDR_W+1 bits; the block guarantees it never exceeds DEPTH and never underflows.
- Reset mid-operation: all state is abandoned immediately; any pending rd_valid is cancelled.

Decomposition:
- Shared package uart_pkg:
  - UART_DATA_W=8.
  - UART_CLKS_PER_BIT=10416, shared with the receiver and transmitter.
  - UART_RX_FIFO_DEPTH=16.
  - UART_RX_FIFO_THRESH=8.
- One sub-module, uart_fifo_ram:
  - DEPTH×8 storage.
  - Synchronous write port, synchronous read port (registered output).
  - No reset on the array.
- Pointer, count and flag logic stay in uart_rx_fifo.

Test Plan:
- Reset, then 3 rx_ready strobes with 0x41, 0x42, 0x43, then 3 rd_en pulses -> rd_data 0x41, 0x42, 0x43, each with a 1-cycle rd_valid pulse; count 3→0; empty=1 at the end.
- 16 writes 0x00..0x0F -> full=1, count=16, irq=1 (count ≥ 8). A 17th write 0xFF -> overrun=1 and the FIFO still holds 0x00..0x0F. clr_ovr -> overrun=0; irq stays 1 until count < 8.
- Full FIFO with rx_ready and rd_en in the same cycle -> 0x00 read out, new byte accepted, overrun stays 0, count stays 16. Draining returns 0x01..0x0F followed by the new byte.
- rd_en while empty -> rd_valid=0, rd_data unchanged, count=0. Empty with rx_ready=0x5A and rd_en together -> count=1, no rd_valid; the next rd_en returns 0x5A.
- Wrap-around: 40 interleaved write/read pairs with an incrementing pattern -> every byte returned in order, with no loss across pointer wrap.
- flush with 5 bytes queued and a concurrent rx_ready -> count=0, empty=1, no rd_valid, overrun unchanged. Asserting reset asynchronously mid-stream -> all outputs return to reset values without waiting for a clock edge.
